// File: rtl/ctrl_instr_prefetch.sv
// Prefetching instruction fetch unit: walks a cyclic program in synchronous ROM,
// buffers words with their addresses in a small queue and pops decoded fields on demand.
module ctrl_instr_prefetch #(
  parameter int VIDWIDTH = 5,
  parameter int RFAWIDTH = 5,
  parameter int DAWIDTH  = 12,
  parameter int IAWIDTH  = 6,
  parameter int DEPTH    = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic                                           flush,
  input  logic [IAWIDTH-1:0]                             prog_last,
  output logic                                           imem_en,
  output logic [IAWIDTH-1:0]                             imem_addr,
  input  logic [2+VIDWIDTH+2*RFAWIDTH+3*DAWIDTH-1:0]     imem_rdata,
  input  logic                                           fetch,
  output logic                                           instr_valid,
  output logic                                           underrun,
  output logic [$clog2(DEPTH):0]                         level,
  output logic [IAWIDTH-1:0]                             instr_pc,
  output logic                                           lstg_f,
  output logic                                           upse_f,
  output logic [VIDWIDTH-1:0]                            vector_id,
  output logic [RFAWIDTH-1:0]                            result_reg,
  output logic [RFAWIDTH-1:0]                            error_reg,
  output logic [DAWIDTH-1:0]                             data_uptr,
  output logic [DAWIDTH-1:0]                             data_lptr,
  output logic [DAWIDTH-1:0]                             coef_ptr
);

  localparam int INSTRWIDTH = 2 + VIDWIDTH + 2*RFAWIDTH + 3*DAWIDTH;
  localparam int PTRW       = $clog2(DEPTH);
  localparam int LVLW       = PTRW + 1;
  localparam int ENTW       = IAWIDTH + INSTRWIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [IAWIDTH-1:0]   pc_q, last_q, infl_addr_q, instr_pc_q;
  logic                 inflight_q, valid_q, underrun_q;
  logic [PTRW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVLW-1:0]      level_q, level_d;
  logic [INSTRWIDTH-1:0] fields_q;
  logic [ENTW-1:0]      mem_q [DEPTH];

  logic                 issue, wr_en, pop;
  logic [LVLW:0]        occ;
  logic [ENTW-1:0]      head;

  // Credit check counts the read still in flight so the queue can never overflow.
  assign occ   = {1'b0, level_q} + (LVLW+1)'(inflight_q);
  assign issue = (state_q == RUN) && !flush && (occ < (LVLW+1)'(DEPTH));
  assign wr_en = inflight_q && !flush;
  assign pop   = fetch && !flush && (level_q != '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVLW'(1);
      2'b01:   level_d = level_q - LVLW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {infl_addr_q, imem_rdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      last_q      <= '0;
      infl_addr_q <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
      instr_pc_q  <= '0;
      fields_q    <= '0;
    end else if (flush) begin
      // Field registers deliberately keep their last values.
      state_q    <= IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        state_q <= RUN;
        pc_q    <= '0;
        last_q  <= prog_last;
      end
      inflight_q <= issue;
      if (issue) begin
        infl_addr_q <= pc_q;
        pc_q        <= (pc_q == last_q) ? '0 : pc_q + IAWIDTH'(1);
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTRW'(1);
        instr_pc_q <= head[ENTW-1 -: IAWIDTH];
        fields_q   <= head[INSTRWIDTH-1:0];
        valid_q    <= 1'b1;
      end
      level_q    <= level_d;
      underrun_q <= fetch && (level_q == '0);
    end
  end

  assign imem_en     = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign underrun    = underrun_q;
  assign level       = level_q;
  assign instr_pc    = instr_pc_q;
  assign {lstg_f, upse_f, vector_id, result_reg, error_reg,
          data_uptr, data_lptr, coef_ptr} = fields_q;

endmodule

// File: tb/tb_ctrl_instr_prefetch.sv
// Directed bench for ctrl_instr_prefetch with a synchronous ROM model.
module tb_ctrl_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, flush = 1'b0, fetch = 1'b0;
  logic [5:0]  prog_last = '0;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [52:0] imem_rdata = '0;
  logic        instr_valid, underrun;
  logic [2:0]  level;
  logic [5:0]  instr_pc;
  logic        lstg_f, upse_f;
  logic [4:0]  vector_id, result_reg, error_reg;
  logic [11:0] data_uptr, data_lptr, coef_ptr;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_instr_prefetch dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .prog_last(prog_last),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetch(fetch), .instr_valid(instr_valid), .underrun(underrun), .level(level),
    .instr_pc(instr_pc), .lstg_f(lstg_f), .upse_f(upse_f), .vector_id(vector_id),
    .result_reg(result_reg), .error_reg(error_reg), .data_uptr(data_uptr),
    .data_lptr(data_lptr), .coef_ptr(coef_ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [52:0] rom_word(input logic [5:0] a);
    if (a == 6'd0)
      return {1'b1, 1'b0, 5'h15, 5'h03, 5'h1C, 12'hABC, 12'h123, 12'hFFF};
    return {a[0], a[1], 5'(a + 6'd3), 5'(a), ~5'(a),
            12'(a) * 12'd100, 12'h500 + 12'(a), 12'(a) * 12'd7};
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= rom_word(imem_addr);

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [52:0] fields();
    return {lstg_f, upse_f, vector_id, result_reg, error_reg, data_uptr, data_lptr, coef_ptr};
  endfunction

  initial begin
    // Reset state
    #1;
    chk("rst_en", 64'(imem_en), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_fields", 64'(fields()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(2);
    chk("idle_en", 64'(imem_en), 64'd0);

    // Fill and stall
    prog_last = 6'd9; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("fill_en0", 64'(imem_en), 64'd1);
    chk("fill_addr0", 64'(imem_addr), 64'd0);
    cyc(1);
    chk("fill_addr1", 64'(imem_addr), 64'd1);
    chk("fill_lvl_e1", 64'(level), 64'd0);
    cyc(1);
    chk("fill_addr2", 64'(imem_addr), 64'd2);
    chk("fill_lvl_e2", 64'(level), 64'd1);
    cyc(1);
    chk("fill_addr3", 64'(imem_addr), 64'd3);
    chk("fill_en3", 64'(imem_en), 64'd1);
    cyc(1);
    chk("fill_en_off", 64'(imem_en), 64'd0);
    chk("fill_lvl3", 64'(level), 64'd3);
    cyc(3);
    chk("stall_lvl4", 64'(level), 64'd4);
    chk("stall_en", 64'(imem_en), 64'd0);
    chk("stall_addr", 64'(imem_addr), 64'd4);
    chk("stall_valid", 64'(instr_valid), 64'd0);

    // First pop and decode of ROM[0]
    fetch = 1'b1;
    cyc(1);
    fetch = 1'b0;
    chk("pop_valid", 64'(instr_valid), 64'd1);
    chk("pop_pc", 64'(instr_pc), 64'd0);
    chk("pop_lvl", 64'(level), 64'd3);
    chk("pop_en", 64'(imem_en), 64'd1);
    chk("pop_addr", 64'(imem_addr), 64'd4);
    chk("dec_lstg", 64'(lstg_f), 64'd1);
    chk("dec_upse", 64'(upse_f), 64'd0);
    chk("dec_vid", 64'(vector_id), 64'h15);
    chk("dec_res", 64'(result_reg), 64'h03);
    chk("dec_err", 64'(error_reg), 64'h1C);
    chk("dec_uptr", 64'(data_uptr), 64'hABC);
    chk("dec_lptr", 64'(data_lptr), 64'h123);
    chk("dec_coef", 64'(coef_ptr), 64'hFFF);

    // Asynchronous reset mid-run
    #1 rst = 1'b0;
    #1;
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_en", 64'(imem_en), 64'd0);
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_pc", 64'(instr_pc), 64'd0);
    chk("arst_fields", 64'(fields()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(3);
    chk("post_rst_en", 64'(imem_en), 64'd0);

    // Underrun on the cycle after start
    prog_last = 6'd2; start = 1'b1;
    cyc(1);
    start = 1'b0; fetch = 1'b1;
    cyc(1);
    fetch = 1'b0;
    chk("urun_pulse", 64'(underrun), 64'd1);
    chk("urun_valid", 64'(instr_valid), 64'd0);
    cyc(1);
    chk("urun_clear", 64'(underrun), 64'd0);
    chk("urun_lvl", 64'(level), 64'd1);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("fl1_lvl", 64'(level), 64'd0);
    cyc(1);
    chk("fl1_lvl_hold", 64'(level), 64'd0);
    chk("fl1_en", 64'(imem_en), 64'd0);

    // Wrap with fetch held; fetch on the ROM-return edge is not bypassed
    prog_last = 6'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    fetch = 1'b1;
    cyc(1);
    chk("nobyp_urun", 64'(underrun), 64'd1);
    chk("nobyp_valid", 64'(instr_valid), 64'd0);
    chk("nobyp_lvl", 64'(level), 64'd1);
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("wrap_pc", 64'(instr_pc), 64'(k % 3));
      chk("wrap_fields", 64'(fields()), 64'(rom_word(6'(k % 3))));
      chk("wrap_lvl", 64'(level), 64'd1);
      chk("wrap_valid", 64'(instr_valid), 64'd1);
    end
    chk("wrap_urun", 64'(underrun), 64'd0);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0; fetch = 1'b0;
    chk("fl2_lvl", 64'(level), 64'd0);
    chk("fl2_valid", 64'(instr_valid), 64'd0);
    chk("fl2_urun", 64'(underrun), 64'd0);
    chk("fl2_hold_fields", 64'(fields()), 64'(rom_word(6'd2)));

    // Flush while address 5 would be issued
    prog_last = 6'd9; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    fetch = 1'b1;
    cyc(4);
    chk("fl3_pre_pc", 64'(instr_pc), 64'd2);
    chk("fl3_pre_en", 64'(imem_en), 64'd1);
    chk("fl3_pre_addr", 64'(imem_addr), 64'd5);
    flush = 1'b1;
    #1;
    chk("fl3_en_gated", 64'(imem_en), 64'd0);
    cyc(1);
    flush = 1'b0; fetch = 1'b0;
    chk("fl3_lvl", 64'(level), 64'd0);
    chk("fl3_valid", 64'(instr_valid), 64'd0);
    cyc(2);
    chk("fl3_lvl_hold", 64'(level), 64'd0);
    chk("fl3_en_idle", 64'(imem_en), 64'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    fetch = 1'b1;
    cyc(1);
    fetch = 1'b0;
    chk("restart_pc", 64'(instr_pc), 64'd0);
    chk("restart_valid", 64'(instr_valid), 64'd1);

    // Single-instruction loop; start and prog_last ignored while running
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    prog_last = 6'd0; start = 1'b1;
    cyc(1);
    start = 1'b0; prog_last = 6'd5;
    chk("loop0_addr0", 64'(imem_addr), 64'd0);
    cyc(1);
    chk("loop0_addr1", 64'(imem_addr), 64'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("loop0_addr2", 64'(imem_addr), 64'd0);
    chk("loop0_en2", 64'(imem_en), 64'd1);
    cyc(3);
    chk("loop0_lvl", 64'(level), 64'd4);
    fetch = 1'b1;
    cyc(1);
    fetch = 1'b0;
    chk("loop0_pc", 64'(instr_pc), 64'd0);
    chk("loop0_pop_lvl", 64'(level), 64'd3);
    chk("loop0_pop_addr", 64'(imem_addr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
